// File: rtl/cavlc_pkg.sv
// Shared definitions for the CAVLC bitstream front end (bit buffer and
// leading-one finder).
package cavlc_pkg;

  localparam int WORD_W      = 32;
  localparam int WIN_W       = 16;
  localparam int BUF_W       = 64;
  localparam int MAX_CONSUME = 16;

  typedef logic [6:0]  level_t;
  typedef logic [4:0]  consume_len_t;
  typedef logic [15:0] win_t;

  // Place a word so that its first bit lands at buffer position 'offset'
  // counted from the MSB; everything below the word stays zero.
  function automatic logic [BUF_W-1:0] align_word(input logic [WORD_W-1:0] word,
                                                  input level_t offset);
    return {word, {WORD_W{1'b0}}} >> offset;
  endfunction

endpackage

// File: rtl/cavlc_bit_buffer.sv
// Left-aligned 64-bit bitstream buffer. Accepts 32-bit words, presents a
// 16-bit MSB-first window and retires 0..16 bits per cycle.
module cavlc_bit_buffer #(
  parameter int WORD_W = 32,
  parameter int WIN_W  = 16,
  parameter int BUF_W  = 64
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic [WORD_W-1:0] InData,
  input  logic              InValid,
  output logic              InReady,
  input  logic              ConsumeEn,
  input  logic [4:0]        ConsumeLen,
  output logic [WIN_W-1:0]  BitstreamShifted,
  output logic              WinValid,
  output logic [6:0]        Level,
  output logic [31:0]       BitPos,
  output logic              ConsumeErr
);
  import cavlc_pkg::*;

  logic [BUF_W-1:0] buf_q;
  level_t           level_q;
  logic [31:0]      bitpos_q;
  logic             err_q;

  logic             win_valid;
  logic             ready;
  logic             len_over;
  consume_len_t     len_clamped;
  level_t           c;
  logic             fill;
  logic             err_set;
  logic [BUF_W-1:0] buf_next;
  level_t           level_next;

  // Window, handshake and per-cycle consume/fill decisions.
  always_comb begin
    win_valid   = (level_q >= level_t'(WIN_W));
    ready       = !Rst && !Flush && (level_q <= level_t'(WORD_W));
    len_over    = (ConsumeLen > consume_len_t'(MAX_CONSUME));
    len_clamped = len_over ? consume_len_t'(MAX_CONSUME) : ConsumeLen;
    c           = (ConsumeEn && win_valid) ? level_t'(len_clamped) : '0;
    fill        = InValid && ready;
    // An illegal consume (too long, or window not yet full) is flagged
    // even though the too-long case still retires the clamped 16 bits.
    err_set     = ConsumeEn && (!win_valid || len_over);
    // The new word goes right behind the post-consume remainder.
    buf_next    = (buf_q << c) | (fill ? align_word(InData, level_q - c) : '0);
    level_next  = level_q - c + (fill ? level_t'(WORD_W) : '0);
  end

  // Buffer state; reset dominates flush, flush dominates fill/consume.
  always_ff @(posedge Clk) begin
    if (Rst || Flush) begin
      buf_q    <= '0;
      level_q  <= '0;
      bitpos_q <= '0;
      err_q    <= 1'b0;
    end else begin
      buf_q    <= buf_next;
      level_q  <= level_next;
      bitpos_q <= bitpos_q + 32'(c);
      if (err_set) err_q <= 1'b1;
    end
  end

  assign BitstreamShifted = buf_q[BUF_W-1 -: WIN_W];
  assign WinValid         = win_valid;
  assign InReady          = ready;
  assign Level            = level_q;
  assign BitPos           = bitpos_q;
  assign ConsumeErr       = err_q;

endmodule

// File: tb/tb_cavlc_bit_buffer.sv
// Bench for cavlc_bit_buffer: a bit-queue reference model checked every
// cycle, plus directed scenarios with hand-computed values.
module tb_cavlc_bit_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        consume_en = 1'b0;
  logic [4:0]  consume_len = '0;
  logic [15:0] window;
  logic        win_valid;
  logic [6:0]  level;
  logic [31:0] bit_pos;
  logic        consume_err;

  int tests = 0;
  int fails = 0;

  cavlc_bit_buffer dut (
    .Clk(clk), .Rst(rst), .Flush(flush),
    .InData(in_data), .InValid(in_valid), .InReady(in_ready),
    .ConsumeEn(consume_en), .ConsumeLen(consume_len),
    .BitstreamShifted(window), .WinValid(win_valid),
    .Level(level), .BitPos(bit_pos), .ConsumeErr(consume_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stream as a queue of bits, oldest first.
  bit          q[$];
  bit [31:0]   m_bitpos = '0;
  bit          m_err = 1'b0;
  bit          started = 1'b0;

  function automatic logic [15:0] m_window();
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++)
      if (i < q.size()) w[15-i] = q[i];
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete(); m_bitpos = '0; m_err = 1'b0; started = 1'b1;
    end else if (flush) begin
      q.delete(); m_bitpos = '0; m_err = 1'b0;
    end else begin
      bit can_take;
      can_take = (q.size() <= 32);
      if (consume_en) begin
        if (q.size() < 16) m_err = 1'b1;
        else begin
          int n;
          n = (consume_len > 16) ? 16 : int'(consume_len);
          if (consume_len > 16) m_err = 1'b1;
          for (int i = 0; i < n; i++) void'(q.pop_front());
          m_bitpos = m_bitpos + n;
        end
      end
      if (in_valid && can_take)
        for (int i = 31; i >= 0; i--) q.push_back(in_data[i]);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      check("model_level", level, q.size());
      check("model_window", window, m_window());
      check("model_winvalid", win_valid, q.size() >= 16);
      check("model_bitpos", bit_pos, m_bitpos);
      check("model_err", consume_err, m_err);
      check("model_inready", in_ready, !rst && !flush && q.size() <= 32);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; consume_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    in_valid = 1'b1; in_data = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic consume(input logic [4:0] n);
    consume_en = 1'b1; consume_len = n;
    tick();
    consume_en = 1'b0;
  endtask

  initial begin
    // Reset state and first word.
    rst = 1'b1;
    tick(); tick();
    check("rst_level", level, 0);
    check("rst_window", window, 0);
    check("rst_winvalid", win_valid, 0);
    check("rst_bitpos", bit_pos, 0);
    check("rst_inready_high", in_ready, 0);
    rst = 1'b0; #1;
    check("idle_inready", in_ready, 1);
    push(32'hFFFF0000);
    check("w1_level", level, 32);
    check("w1_winvalid", win_valid, 1);
    check("w1_window", window, 16'hFFFF);

    // Consume 5 then 3 from one word.
    do_reset();
    push(32'h12345678);
    consume(5'd5);
    check("c5_window", window, 16'h468A);
    check("c5_level", level, 27);
    check("c5_bitpos", bit_pos, 5);
    consume(5'd3);
    check("c3_window", window, 16'h3456);
    check("c3_level", level, 24);
    check("c3_bitpos", bit_pos, 8);

    // Simultaneous consume and fill.
    do_reset();
    push(32'hAAAA5555);
    in_valid = 1'b1; in_data = 32'hC3C3C3C3; consume_en = 1'b1; consume_len = 5'd16;
    tick();
    in_valid = 1'b0; consume_en = 1'b0; #1;
    check("cf_window", window, 16'h5555);
    check("cf_level", level, 48);
    check("cf_inready", in_ready, 0);
    consume(5'd16);
    check("cf2_window", window, 16'hC3C3);
    check("cf2_level", level, 32);
    check("cf2_inready", in_ready, 1);

    // Over-long consume and consume on a short tail.
    do_reset();
    push(32'hF0F0F0F7);
    consume(5'd12);
    check("l20_level", level, 20);
    consume(5'd17);
    check("ovr_level", level, 4);
    check("ovr_err", consume_err, 1);
    check("ovr_winvalid", win_valid, 0);
    check("ovr_window", window, 16'h7000);
    check("ovr_bitpos", bit_pos, 28);
    consume(5'd2);
    check("tail_level", level, 4);
    check("tail_err", consume_err, 1);
    check("tail_bitpos", bit_pos, 28);

    // Flush at Level 40 with a word and a consume offered.
    do_reset();
    push(32'h11112222);
    push(32'h33334444);
    check("fl_full", level, 64);
    consume(5'd20);
    check("fl_err", consume_err, 1);
    consume(5'd8);
    check("fl_level40", level, 40);
    in_valid = 1'b1; in_data = 32'h55556666; consume_en = 1'b1; consume_len = 5'd4;
    flush = 1'b1; #1;
    check("fl_inready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; consume_en = 1'b0; #1;
    check("fl_level", level, 0);
    check("fl_bitpos", bit_pos, 0);
    check("fl_errclr", consume_err, 0);
    check("fl_inready_after", in_ready, 1);

    // Reset mid-stream with a consume pending.
    do_reset();
    push(32'h89ABCDEF);
    consume(5'd16);
    push(32'h01234567);
    check("mr_level48", level, 48);
    rst = 1'b1; consume_en = 1'b1; consume_len = 5'd16;
    tick();
    check("mr_level", level, 0);
    check("mr_bitpos", bit_pos, 0);
    check("mr_window", window, 0);
    check("mr_winvalid", win_valid, 0);
    check("mr_inready", in_ready, 0);
    rst = 1'b0; consume_en = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
